// File: rtl/conv_layer_sequencer.sv
// Sequences one conv-engine run, then drains OUT_COUNT result bytes onto a valid/ready stream.
// Optional WAIT_DONE watchdog is enabled by defining CONV_SEQ_TIMEOUT_EN.
//
// state      | meaning
// S_IDLE     | waiting for cmd_start after reset
// S_START    | eng_start pulse cycle
// S_WAIT_DONE| waiting for a rising edge on eng_done (watchdog runs here)
// S_FETCH    | eng_read_addr holds index, engine read in flight
// S_CAPTURE  | engine byte captured into the stream register
// S_HOLD     | byte offered downstream until m_ready
// S_DONE     | run finished, idle-equivalent
// S_ERR      | watchdog expired, idle-equivalent with sticky error
module conv_layer_sequencer #(
   parameter int unsigned OUT_COUNT = 21632,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 8
`ifdef CONV_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cmd_start,
   output logic              busy,
   output logic              eng_start,
   input  logic              eng_done,
   output logic [ADDR_W-1:0] eng_read_addr,
   input  logic [DATA_W-1:0] eng_read_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              run_done,
   output logic              error
);

   localparam int unsigned IDX_W = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_DONE,
      S_FETCH,
      S_CAPTURE,
      S_HOLD,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] index;
   logic             done_q;
   logic             done_rise;

   assign done_rise = eng_done && !done_q;

`ifdef CONV_SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wd_cnt;
   logic            err_q;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         index         <= '0;
         done_q        <= 1'b0;
         busy          <= 1'b0;
         eng_start     <= 1'b0;
         eng_read_addr <= '0;
         m_valid       <= 1'b0;
         m_data        <= '0;
         m_last        <= 1'b0;
         run_done      <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
         wd_cnt        <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         done_q    <= eng_done;
         eng_start <= 1'b0;
         run_done  <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (cmd_start) begin
                  state     <= S_START;
                  busy      <= 1'b1;
                  eng_start <= 1'b1;
                  index     <= '0;
`ifdef CONV_SEQ_TIMEOUT_EN
                  err_q     <= 1'b0;
                  wd_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
               end
            end
            S_START: state <= S_WAIT_DONE;
            S_WAIT_DONE: begin
               // only a fresh edge counts; a level left over from a prior run is ignored
               if (done_rise) begin
                  state         <= S_FETCH;
                  eng_read_addr <= ADDR_W'(index);
               end
`ifdef CONV_SEQ_TIMEOUT_EN
               else if (wd_cnt == '0) begin
                  state <= S_ERR;
                  err_q <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
`endif
            end
            S_FETCH: state <= S_CAPTURE;
            S_CAPTURE: begin
               m_data  <= eng_read_data;
               m_valid <= 1'b1;
               m_last  <= (index == LAST_IDX);
               state   <= S_HOLD;
            end
            S_HOLD: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  if (m_last) begin
                     m_last   <= 1'b0;
                     run_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     index         <= index + IDX_W'(1);
                     eng_read_addr <= ADDR_W'(index + IDX_W'(1));
                     state         <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: random engine contents and random backpressure checked
// against an in-order byte model, plus done-edge, command-ignore, reset-abort and watchdog cases.
module tb_conv_layer_sequencer;

   localparam int N      = 40;
   localparam int BUDGET = 2000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_start = 1'b0;
   logic        eng_done = 1'b0;
   logic        m_ready = 1'b0;
   logic        busy, eng_start, m_valid, m_last, run_done, error;
   logic [31:0] eng_read_addr;
   logic [7:0]  eng_read_data = 8'h00;
   logic [7:0]  m_data;
   logic [7:0]  mem [N];

   int n_pass = 0;
   int n_total = 0;
   int n_start = 0;
   int n_done = 0;

   conv_layer_sequencer #(
      .OUT_COUNT(N),
      .ADDR_W(32),
      .DATA_W(8)
`ifdef CONV_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(1000)
`endif
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .cmd_start(cmd_start),
      .busy(busy),
      .eng_start(eng_start),
      .eng_done(eng_done),
      .eng_read_addr(eng_read_addr),
      .eng_read_data(eng_read_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data(m_data),
      .m_last(m_last),
      .run_done(run_done),
      .error(error)
   );

   always #5 clk = ~clk;

   // engine result memory: data appears one cycle after the address
   always @(posedge clk)
      eng_read_data <= (eng_read_addr < 32'(N)) ? mem[eng_read_addr[5:0]] : 8'h00;

   always @(negedge clk) begin
      if (eng_start === 1'b1) n_start <= n_start + 1;
      if (run_done === 1'b1) n_done <= n_done + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(255));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_eng_start"}, eng_start, 0);
      check({tag, "_addr"}, eng_read_addr, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_run_done"}, run_done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   task automatic start_run();
      cmd_start = 1'b1;
      tick();
      check("start_pulse", eng_start, 1);
      check("start_busy", busy, 1);
      cmd_start = 1'b0;
      tick();
      check("start_pulse_end", eng_start, 0);
   endtask

   // raise eng_done and measure edges until the first byte is offered
   task automatic done_edge_latency();
      int k;
      eng_done = 1'b1;
      tick();
      check("addr0_after_edge", eng_read_addr, 0);
      k = 1;
      while (m_valid !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      check("valid_latency", k, 3);
   endtask

   task automatic stream(input int pct_ready, input bit poke_cmd, input int stop_at, output int got);
      int   cyc;
      bit   stalled;
      logic [7:0] pd;
      logic pl;
      got = 0;
      cyc = 0;
      stalled = 1'b0;
      pd = 8'h00;
      pl = 1'b0;
      while (got < stop_at && cyc < BUDGET) begin
         if (stalled) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, pd);
            check("stall_last", m_last, pl);
         end
         m_ready = ($urandom_range(99) < pct_ready);
         if (poke_cmd) cmd_start = 1'($urandom_range(1));
         if (m_valid === 1'b1 && m_ready) begin
            check("byte_data", m_data, mem[got]);
            check("byte_last", m_last, (got == N - 1));
            got++;
            stalled = 1'b0;
         end else begin
            stalled = (m_valid === 1'b1);
         end
         pd = m_data;
         pl = m_last;
         tick();
         cyc++;
      end
      check("stream_in_budget", (cyc < BUDGET), 1);
      m_ready = 1'b0;
      cmd_start = 1'b0;
   endtask

   initial begin
      int got, s0, d0, k;
      fill_mem();
      repeat (3) tick();
      check_all_zero("reset");
      resetn = 1'b1;
      tick();

      // run 1: engine done after 500 cycles, no backpressure
      s0 = n_start;
      d0 = n_done;
      start_run();
      repeat (500) tick();
      check("run1_still_waiting", m_valid, 0);
      done_edge_latency();
      stream(100, 1'b0, N, got);
      check("run1_count", got, N);
      check("run1_run_done", run_done, 1);
      check("run1_busy_low", busy, 0);
      check("run1_error", error, 0);
      tick();
      check("run1_run_done_pulse", run_done, 0);
      check("run1_eng_starts", n_start - s0, 1);
      check("run1_run_dones", n_done - d0, 1);

      // run 2: eng_done still high, stray commands, 50% backpressure
      fill_mem();
      s0 = n_start;
      d0 = n_done;
      start_run();
      for (int i = 0; i < 30; i++) begin
         cmd_start = 1'($urandom_range(1));
         tick();
      end
      cmd_start = 1'b0;
      tick();
      check("stale_done_no_stream", m_valid, 0);
      check("stale_done_busy", busy, 1);
      check("stale_done_addr_held", eng_read_addr, N - 1);
      check("wait_cmd_ignored", n_start - s0, 1);
      eng_done = 1'b0;
      repeat (3) tick();
      done_edge_latency();
      stream(50, 1'b1, N, got);
      check("run2_count", got, N);
      check("run2_run_done", run_done, 1);
      tick();
      check("run2_eng_starts", n_start - s0, 1);
      check("run2_run_dones", n_done - d0, 1);

      // run 3: reset in the middle of the stream
      fill_mem();
      eng_done = 1'b0;
      s0 = n_start;
      d0 = n_done;
      start_run();
      repeat (10) tick();
      done_edge_latency();
      stream(100, 1'b0, 20, got);
      m_ready = 1'b1;
      #2 resetn = 1'b0;
      #1;
      check_all_zero("midrun_reset");
      m_ready = 1'b0;
      eng_done = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      repeat (3) tick();
      check("abort_no_run_done", n_done - d0, 0);
      check("abort_eng_starts", n_start - s0, 1);
      s0 = n_start;
      start_run();
      repeat (5) tick();
      done_edge_latency();
      stream(100, 1'b0, N, got);
      check("rerun_count", got, N);
      check("rerun_run_done", run_done, 1);
      check("rerun_eng_starts", n_start - s0, 1);
      tick();

`ifdef CONV_SEQ_TIMEOUT_EN
      // watchdog: eng_done never rises
      eng_done = 1'b0;
      start_run();
      k = 0;
      while (error !== 1'b1 && k < 1100) begin
         tick();
         k++;
      end
      check("timeout_cycles", k, 1000);
      check("timeout_error", error, 1);
      check("timeout_busy", busy, 0);
      check("timeout_no_stream", m_valid, 0);
      repeat (5) tick();
      check("timeout_sticky", error, 1);
      start_run();
      check("timeout_cleared", error, 0);
      check("timeout_restart_busy", busy, 1);
`else
      k = 0;
      repeat (20) begin
         if (error !== 1'b0) k++;
         tick();
      end
      check("error_tied_low", k, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Controller that sequences one run of the 32-channel 3x3 conv engine and drains its result memory as a byte stream. It accepts a start command, pulses the engine start, waits for the engine's completion edge, then walks the engine read port from address 0 to OUT_COUNT-1 and presents each byte on a valid/ready output stream toward the next layer or the host bridge. It sits between the SoC control path and the conv engine, replacing testbench-style manual address sweeping.

## Interface
- OUT_COUNT, 21632, number of result bytes per run (26x26x32).
- ADDR_W, 32, engine read-address width.
- DATA_W, 8, engine read-data and stream width.
- TIMEOUT_CYCLES, 1000000, watchdog limit in WAIT_DONE (only with CONV_SEQ_TIMEOUT_EN).

- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_start  in  1  run request, sampled in IDLE/DONE/ERR only.
- busy  out  1  high from accepted cmd_start until DONE/ERR.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_done  in  1  engine completion level.
- eng_read_addr  out  ADDR_W  engine result address.
- eng_read_data  in  DATA_W  engine result byte, valid one cycle after address.
- m_valid  out  1  stream byte valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  stream byte.
- m_last  out  1  high with final byte (index OUT_COUNT-1).
- run_done  out  1  one-cycle pulse after last byte accepted.
- error  out  1  sticky watchdog error.

## Operation
- States: IDLE, START, WAIT_DONE, FETCH, CAPTURE, HOLD, DONE, ERR.
- IDLE/DONE/ERR + cmd_start=1 -> START; clears error, index, watchdog.
- START: eng_start=1 for exactly this cycle -> WAIT_DONE.
- WAIT_DONE: completion = rising edge of eng_done (registered previous value); a level left high from a prior run is not completion. Edge -> FETCH.
- FETCH: eng_read_addr=index -> CAPTURE.
- CAPTURE: m_data <= eng_read_data, m_valid <= 1, m_last <= (index==OUT_COUNT-1) -> HOLD.
- HOLD: m_data/m_last stable while m_valid && !m_ready. On m_ready: m_valid <= 0; if last -> DONE with run_done pulse, else index+1 -> FETCH.
- DONE: idle-equivalent, busy=0.
- cmd_start outside IDLE/DONE/ERR is ignored (no queueing).
- index is a counter of width clog2(OUT_COUNT); eng_read_addr is zero-extended to ADDR_W; index never wraps (terminates at OUT_COUNT-1).

## Timing
- Reset: all outputs 0, state IDLE, index 0; reset mid-run aborts immediately, no run_done, no eng_start.
- cmd_start at cycle N -> eng_start at N+1 -> earliest FETCH cycle after eng_done edge is detected.
- eng_done rising at cycle M (sampled) -> eng_read_addr=0 at M+1, m_valid=1 at M+3.
- Per byte: minimum 3 cycles (FETCH, CAPTURE, HOLD with m_ready=1); full run minimum 3*OUT_COUNT cycles after completion.
- eng_read_addr holds its value outside FETCH; engine may read it any time.
- run_done asserts the cycle after the final handshake; busy drops the same cycle.

## Configuration
- CONV_SEQ_TIMEOUT_EN defined: cycle counter in WAIT_DONE; reaching TIMEOUT_CYCLES without completion -> ERR, error=1 (sticky until next accepted cmd_start), busy=0, no stream output.
- Undefined: no counter, WAIT_DONE waits indefinitely, error tied to 0, ERR unreachable.

## Test plan
- Reset then cmd_start, engine model raises eng_done after 500 cycles, m_ready=1 -> single eng_start pulse, 21632 bytes in address order matching model, m_last only on byte 21631, one run_done.
- Random m_ready backpressure (50%) -> m_data/m_last stable while stalled, no byte lost or duplicated, byte count 21632.
- eng_done left high from previous run, new cmd_start -> no streaming until eng_done falls and rises again.
- cmd_start pulsed during WAIT_DONE and HOLD -> ignored, exactly one eng_start per run.
- resetn low during byte 100 stream -> all outputs 0 asynchronously, no run_done; post-reset run restarts at address 0.
- With CONV_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=1000, eng_done never rises -> error=1 and busy=0 after 1000 WAIT_DONE cycles; next cmd_start clears error.
